// File: rtl/gray_dec_pkg.sv
// Shared types for the streaming Gray-to-binary decoder and its sequence checker.
package gray_dec_pkg;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_REPEAT  = 2'b01,
        ERR_REVERSE = 2'b10,
        ERR_JUMP    = 2'b11
    } err_code_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_TRACK = 1'b1
    } seq_state_t;

    localparam int MIN_WIDTH = 2;

endpackage : gray_dec_pkg

// File: rtl/gray2bin_comb.sv
// Purely combinational Gray-to-binary conversion; each binary bit is the XOR of all Gray bits at or above it.
module gray2bin_comb #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Prefix-XOR form avoids a combinational chain that reads its own output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule : gray2bin_comb

// File: rtl/gray_bin_decoder.sv
// Streaming Gray-to-binary decoder with a one-deep output register and optional +1 sequence checker.
// Define GRAY_DEC_SEQ_CHECK_EN to build the checker, prev-word registers and saturating error counter.
module gray_bin_decoder
    import gray_dec_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 resync,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic             accept;
    logic [WIDTH-1:0] bin_dec_p0;
    logic             vld_p1;
    logic [WIDTH-1:0] bin_p1;

    gray2bin_comb #(
        .WIDTH (WIDTH)
    ) u_gray2bin (
        .gray (gray_in),
        .bin  (bin_dec_p0)
    );

    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    // Stage p0 -> p1: output register loads on every accept, drains when consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            bin_p1 <= '0;
        end else if (accept) begin
            vld_p1 <= 1'b1;
            bin_p1 <= bin_dec_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign bin_out   = bin_p1;

`ifdef GRAY_DEC_SEQ_CHECK_EN
    localparam int CNT_W = $clog2(WIDTH + 1);

    seq_state_t             state_q;
    seq_state_t             state_d;
    err_code_t              code_p0;
    err_code_t              code_p1;
    logic [WIDTH-1:0]       prev_gray_q;
    logic [WIDTH-1:0]       prev_bin_q;
    logic [WIDTH-1:0]       bin_inc_p0;
    logic [CNT_W-1:0]       dist_p0;
    logic [ERR_CNT_W-1:0]   err_cnt_q;

    function automatic logic [CNT_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
        return (&c) ? c : c + ERR_CNT_W'(1);
    endfunction

    assign dist_p0    = popcount(gray_in ^ prev_gray_q);
    assign bin_inc_p0 = prev_bin_q + WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A resync coinciding with an accept makes that word the fresh reference.
    always_comb begin
        state_d = state_q;
        code_p0 = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    state_d = ST_TRACK;
                    if (!resync) begin
                        if (dist_p0 == CNT_W'(0)) begin
                            code_p0 = ERR_REPEAT;
                        end else if (dist_p0 > CNT_W'(1)) begin
                            code_p0 = ERR_JUMP;
                        end else if (bin_dec_p0 != bin_inc_p0) begin
                            code_p0 = ERR_REVERSE;
                        end
                    end
                end else if (resync) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage p0 -> p1: error class travels with bin_p1; flagged words still become the reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_gray_q <= '0;
            prev_bin_q  <= '0;
            code_p1     <= ERR_NONE;
            err_cnt_q   <= '0;
        end else if (accept) begin
            prev_gray_q <= gray_in;
            prev_bin_q  <= bin_dec_p0;
            code_p1     <= code_p0;
            if (code_p0 != ERR_NONE) begin
                err_cnt_q <= sat_inc(err_cnt_q);
            end
        end
    end

    assign step_err = (code_p1 != ERR_NONE);
    assign err_code = code_p1;
    assign err_cnt  = err_cnt_q;
`else
    logic unused_resync;

    assign unused_resync = resync;
    assign step_err      = 1'b0;
    assign err_code      = ERR_NONE;
    assign err_cnt       = '0;
`endif

endmodule : gray_bin_decoder

// File: tb/tb_gray_bin_decoder.sv
// Directed self-checking bench for gray_bin_decoder (WIDTH=4); expectations follow GRAY_DEC_SEQ_CHECK_EN.
module tb_gray_bin_decoder;

`ifdef GRAY_DEC_SEQ_CHECK_EN
    localparam bit SEQ = 1'b1;
`else
    localparam bit SEQ = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] gray_in;
    logic       resync;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] bin_out;
    logic       step_err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;

    gray_bin_decoder #(
        .WIDTH     (4),
        .ERR_CNT_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .resync    (resync),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .step_err  (step_err),
        .err_code  (err_code),
        .err_cnt   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [3:0] b, input logic e, input logic [1:0] c,
                           input logic [7:0] n);
        chk({tag, ".valid"}, out_valid, 1'b1);
        chk({tag, ".bin"}, bin_out, b);
        chk({tag, ".step_err"}, step_err, SEQ ? e : 1'b0);
        chk({tag, ".err_code"}, err_code, SEQ ? c : 2'b00);
        chk({tag, ".err_cnt"}, err_cnt, SEQ ? n : 8'd0);
    endtask

    logic [3:0] exh_gray [16];
    logic [3:0] wrap_gray[5];
    logic [3:0] wrap_bin [5];

    initial begin
        exh_gray  = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                      4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        wrap_gray = '{4'b1011, 4'b1001, 4'b1000, 4'b0000, 4'b0001};
        wrap_bin  = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};

        rst = 1'b1; in_valid = 1'b0; gray_in = '0; resync = 1'b0; out_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("reset.out_valid", out_valid, 1'b0);
        chk("reset.bin_out", bin_out, 4'd0);
        chk("reset.step_err", step_err, 1'b0);
        chk("reset.err_code", err_code, 2'b00);
        chk("reset.err_cnt", err_cnt, 8'd0);
        chk("reset.in_ready", in_ready, 1'b1);

        // exhaustive decode, back-to-back
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; gray_in = exh_gray[i];
            tick();
            chk_out($sformatf("exh%0d", i), 4'(i), 1'b0, 2'b00, 8'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", out_valid, 1'b0);

        // legal sequence through wrap after a fresh reference
        resync = 1'b1;
        tick();
        resync = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; gray_in = wrap_gray[i];
            tick();
            chk_out($sformatf("wrap%0d", i), wrap_bin[i], 1'b0, 2'b00, 8'd0);
        end
        in_valid = 1'b0;

        // error classes
        resync = 1'b1;
        tick();
        resync = 1'b0;
        in_valid = 1'b1;
        gray_in = 4'b0001; tick(); chk_out("err.first",   4'd1, 1'b0, 2'b00, 8'd0);
        gray_in = 4'b0001; tick(); chk_out("err.repeat",  4'd1, 1'b1, 2'b01, 8'd1);
        gray_in = 4'b0000; tick(); chk_out("err.reverse", 4'd0, 1'b1, 2'b10, 8'd2);
        gray_in = 4'b0110; tick(); chk_out("err.jump",    4'd4, 1'b1, 2'b11, 8'd3);
        in_valid = 1'b0;
        tick();
        chk("err.drain", out_valid, 1'b0);

        // backpressure: word held, input stalled
        out_ready = 1'b0; in_valid = 1'b1; gray_in = 4'b0011;
        tick();
        chk_out("bp.load", 4'd2, 1'b1, 2'b11, 8'd4);
        chk("bp.in_ready0", in_ready, 1'b0);
        gray_in = 4'b0010;
        tick(); tick();
        chk_out("bp.hold", 4'd2, 1'b1, 2'b11, 8'd4);
        chk("bp.in_ready1", in_ready, 1'b0);
        out_ready = 1'b1;
        #1;
        chk("bp.release_ready", in_ready, 1'b1);
        tick();
        chk_out("bp.next", 4'd3, 1'b0, 2'b00, 8'd4);

        // resync coinciding with accept, then a legal follow-on
        resync = 1'b1; gray_in = 4'b0110;
        tick();
        resync = 1'b0;
        chk_out("resync.accept", 4'd4, 1'b0, 2'b00, 8'd4);
        gray_in = 4'b0111;
        tick();
        chk_out("resync.track", 4'd5, 1'b0, 2'b00, 8'd4);
        in_valid = 1'b0;

        // reset while a word is pending
        out_ready = 1'b0; in_valid = 1'b1; gray_in = 4'b0101;
        tick();
        in_valid = 1'b0;
        chk("mid.pending", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid.out_valid", out_valid, 1'b0);
        chk("mid.err_cnt", err_cnt, 8'd0);
        chk("mid.bin_out", bin_out, 4'd0);
        chk("mid.in_ready", in_ready, 1'b1);
        out_ready = 1'b1; in_valid = 1'b1; gray_in = 4'b0110;
        tick();
        in_valid = 1'b0;
        chk_out("mid.first", 4'd4, 1'b0, 2'b00, 8'd0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_gray_bin_decoder
